// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions.
//   - ps2_state_e: host transmitter FSM states
//   - PS2_CMD_*: common host-to-device command bytes
//   - DEF_*: default cycle counts at 50 MHz
//   - ps2_odd_parity(): parity bit that makes the 9-bit frame odd
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        DATA,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    localparam int unsigned DEF_CLK_INHIBIT_CYCLES   = 5000;    // 100 us
    localparam int unsigned DEF_START_TIMEOUT_CYCLES = 750000;  // 15 ms
    localparam int unsigned DEF_BIT_TIMEOUT_CYCLES   = 100000;  // 2 ms

    localparam int unsigned CNT_W = 20;

    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizers for PS2_CLK / PS2_DAT plus a
// falling-edge detector on the synchronized clock.
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   ps2_clk_i   raw PS2_CLK pin
//   ps2_dat_i   raw PS2_DAT pin
//   clk_s_o     synchronized PS2_CLK
//   dat_s_o     synchronized PS2_DAT
//   clk_fall_o  synchronized PS2_CLK was 1 last cycle and is 0 now
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_s_o,
    output logic dat_s_o,
    output logic clk_fall_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;

    // Reset to the bus idle level (high) so leaving reset never looks like an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_s_o    = clk_sync_q[1];
    assign dat_s_o    = dat_sync_q[1];
    assign clk_fall_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Runs clock inhibit, request-to-send, 8 data bits LSB first, odd parity,
// stop and device acknowledge for one command byte.
//   CLOCK_50    system clock
//   reset       synchronous active-high reset
//   cmd_data    command byte (sampled on accept only)
//   cmd_valid   command request
//   cmd_ready   high in IDLE (combinational)
//   ps2_clk_in  raw PS2_CLK pin
//   ps2_dat_in  raw PS2_DAT pin
//   ps2_clk_oe  1 = pull PS2_CLK low
//   ps2_dat_oe  1 = pull PS2_DAT low
//   tx_busy     high whenever not IDLE
//   cmd_sent    one-cycle pulse on device ACK
//   cmd_error   one-cycle pulse on NACK or timeout
// Build option: define PS2_HOST_TX_TIMEOUT_EN to enable the start/bit
// timeouts; without it a transfer waits for device edges indefinitely.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_INHIBIT_CYCLES   = DEF_CLK_INHIBIT_CYCLES,
    parameter int unsigned START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
    parameter int unsigned BIT_TIMEOUT_CYCLES   = DEF_BIT_TIMEOUT_CYCLES
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       tx_busy,
    output logic       cmd_sent,
    output logic       cmd_error
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(CLK_INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{START_TIMEOUT_CYCLES, BIT_TIMEOUT_CYCLES};
`endif

    logic clk_s, dat_s, clk_fall;

    ps2_line_sync u_sync (
        .clk_i      (CLOCK_50),
        .rst_i      (reset),
        .ps2_clk_i  (ps2_clk_in),
        .ps2_dat_i  (ps2_dat_in),
        .clk_s_o    (clk_s),
        .dat_s_o    (dat_s),
        .clk_fall_o (clk_fall)
    );

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [8:0]       shift_q, shift_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             busy_q, busy_d;
    logic             sent_q, sent_d;
    logic             err_q, err_d;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            sent_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            busy_q   <= busy_d;
            sent_q   <= sent_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        sent_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (cmd_valid) begin
                    state_d  = INHIBIT;
                    clk_oe_d = 1'b1;
                    shift_d  = {ps2_odd_parity(cmd_data), cmd_data};
                end
            end
            INHIBIT: begin
                // Start bit goes out on the same edge the clock is released.
                if (cnt_q == INH_LAST) begin
                    state_d  = REQUEST;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                end
            end
            REQUEST: begin
                if (clk_fall) begin
                    state_d  = DATA;
                    dat_oe_d = ~shift_q[0];
                    shift_d  = {1'b0, shift_q[8:1]};
                    bitcnt_d = 4'd1;
                end
`ifdef PS2_HOST_TX_TIMEOUT_EN
                else if (cnt_q >= START_LAST) begin
                    state_d  = IDLE;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                end
`endif
            end
            DATA, STOP, ACK, WAIT_IDLE: begin
                if (state_q == WAIT_IDLE && clk_s && dat_s) begin
                    state_d = IDLE;
                    sent_d  = 1'b1;
                end else if (clk_fall && state_q != WAIT_IDLE) begin
                    if (state_q == DATA) begin
                        // Edge 9 drives parity; the next edge is the stop bit.
                        dat_oe_d = ~shift_q[0];
                        shift_d  = {1'b0, shift_q[8:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd8) state_d = STOP;
                    end else if (state_q == STOP) begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end else if (dat_s) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
`ifdef PS2_HOST_TX_TIMEOUT_EN
                else if (cnt_q >= BIT_LAST) begin
                    state_d  = IDLE;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                end
`endif
            end
            default: begin
                state_d  = IDLE;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
            end
        endcase

        // Edges seen while we hold the clock low (INHIBIT) are our own and
        // must not stretch the inhibit time, so only device-phase edges reload.
        if (state_d != state_q ||
            (clk_fall && state_q != IDLE && state_q != INHIBIT))
            cnt_d = '0;

        busy_d = (state_d != IDLE);
    end

    assign cmd_ready  = (state_q == IDLE);
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign tx_busy    = busy_q;
    assign cmd_sent   = sent_q;
    assign cmd_error  = err_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the sending side of the PS/2 link our keyboard receiver listens on. It accepts one command byte through a valid/ready handshake and runs the full request-to-send sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop, and the device acknowledge. Typical commands are 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset). It sits beside the PS/2 receiver under the top level, shares the PS2_CLK/PS2_DAT open-drain pins, and reports busy so the receiver can ignore its own traffic.

## Interface
Parameters:
- CLK_INHIBIT_CYCLES, 5000: cycles PS2_CLK is held low before start (100 µs at 50 MHz).
- START_TIMEOUT_CYCLES, 750000: maximum wait for the device's first falling edge (15 ms).
- BIT_TIMEOUT_CYCLES, 100000: maximum gap between consecutive device falling edges (2 ms).

Ports:
- CLOCK_50  in  1  system clock; one clock only.
- reset  in  1  synchronous, active-high reset.
- cmd_data  in  8  command byte.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS2_CLK pin value.
- ps2_dat_in  in  1  raw PS2_DAT pin value.
- ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release.
- ps2_dat_oe  out  1  1 = drive PS2_DAT low, 0 = release.
- tx_busy  out  1  high in every state except IDLE.
- cmd_sent  out  1  one-cycle pulse when the device ACKs.
- cmd_error  out  1  one-cycle pulse on a NACK or a timeout.

## Operation
- Input conditioning: ps2_clk_in and ps2_dat_in each pass through a 2-FF synchronizer. A falling edge means the synchronized clock was 1 on the previous cycle and is 0 now.
- Accept: a command is accepted on the cycle cmd_valid & cmd_ready. On that cycle the block latches {odd_parity, cmd_data} into a 9-bit shift register, where odd_parity = ~^cmd_data.
- States:
  - IDLE: both oe = 0. Go to INHIBIT on accept.
  - INHIBIT: clk_oe = 1. After CLK_INHIBIT_CYCLES cycles, set dat_oe = 1 (start bit) and go to REQUEST.
  - REQUEST: clk_oe = 0, dat_oe stays 1. The first falling edge drives bit 0 (dat_oe = ~shift[0]); shift right; bitcnt = 1; go to DATA.
  - DATA: each falling edge drives the next shift bit. After the edge that drives the parity bit (bitcnt = 9), go to STOP.
  - STOP: the next falling edge releases data (dat_oe = 0); go to ACK.
  - ACK: the next falling edge samples synchronized ps2_dat_in. 0 goes to WAIT_IDLE; 1 pulses cmd_error and goes to IDLE.
  - WAIT_IDLE: wait until both synchronized lines are high, then pulse cmd_sent and go to IDLE.
- Bit counter is 4 bits wide. The cycle counter is 20 bits wide, reloads on every state change and every falling edge, and saturates rather than wrapping.
- Timeout (when compiled in):
  - Applies in REQUEST (START_TIMEOUT_CYCLES) and in DATA/STOP/ACK/WAIT_IDLE (BIT_TIMEOUT_CYCLES).
  - On expiry: release both lines, pulse cmd_error, go to IDLE.
- cmd_valid outside IDLE is ignored; nothing is queued.
- cmd_data only needs to be stable on the accept cycle.

## Timing
- Reset values: state IDLE, ps2_clk_oe = 0, ps2_dat_oe = 0, tx_busy = 0, cmd_sent = 0, cmd_error = 0, cmd_ready = 1 (combinational from IDLE).
- Reset mid-transfer: both lines are released on the first clock edge with reset high, and no cmd_sent or cmd_error pulse is produced.
- Accept to clk_oe = 1: 1 cycle.
- clk_oe high time: exactly CLK_INHIBIT_CYCLES cycles.
- dat_oe asserts on the same edge that clk_oe deasserts.
- Data pin update: dat_oe changes 1 cycle after the falling edge is detected, i.e. 3 cycles after the pin edge. This is well inside the device's half period.
- cmd_sent and cmd_error are mutually exclusive and never both asserted.
- tx_busy rises on the accept edge and falls on the same edge as the cmd_sent/cmd_error pulse.
- Outputs are all registered except cmd_ready.

## Configuration
- PS2_HOST_TX_TIMEOUT_EN
  - Defined: START and BIT timeouts are active as described above.
  - Undefined: the timeout logic and the 20-bit counter's timeout compare are removed. The FSM waits indefinitely for device edges; only reset recovers a hung transfer. The inhibit counter remains.

## Structure
- Shared package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQUEST, DATA, STOP, ACK, WAIT_IDLE);
  - command constants PS2_CMD_SET_LEDS = 8'hED, PS2_CMD_ENABLE = 8'hF4, PS2_CMD_RESET = 8'hFF;
  - default cycle counts.
- One sub-module, ps2_line_sync: the 2-FF synchronizer plus falling-edge detector. The receiver can reuse it.

## Test plan
- Send 8'hED with a device model clocking at 12.5 kHz and ACKing low:
  - clk_oe high for exactly 5000 cycles;
  - data pins on successive falling edges read 1,0,1,1,0,1,1,1, then parity 1, then stop;
  - one cmd_sent pulse, no cmd_error.
- Send 8'hF4: parity bit 0 on the 9th falling edge; cmd_sent pulses once.
- Device leaves data high on the ACK edge: cmd_error pulses once, cmd_sent stays 0, state returns to IDLE and cmd_ready = 1.
- Device never clocks after the start bit: after 750000 cycles in REQUEST, cmd_error pulses and both oe = 0. With PS2_HOST_TX_TIMEOUT_EN undefined, tx_busy stays high until reset.
- Assert reset after the 4th data bit: ps2_clk_oe = ps2_dat_oe = 0 and tx_busy = 0 on the next edge; no pulse. A following 8'hFF transfer completes normally.
- Hold cmd_valid high with 8'hAA while a transfer is busy: cmd_ready = 0, and the in-flight byte shifted out is unchanged.
